// File: rtl/i2s_delay_sum_beamformer.sv
// Master-mode multi-line I2S receiver with a per-channel frame history and a
// delay-and-sum beam output produced once per frame.
module i2s_delay_sum_beamformer #(
  parameter int NUM_LINES   = 2,
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32,
  parameter int MAX_DELAY   = 8,
  localparam int CH         = 2 * NUM_LINES,
  localparam int DELAY_BITS = $clog2(MAX_DELAY),
  localparam int CH_BITS    = (CH > 2) ? $clog2(CH) : 1,
  localparam int OUT_BITS   = SAMPLE_BITS + $clog2(CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_LINES-1:0]  i2s_sd,
  output logic                  i2s_ws,
  input  logic                  cfg_we,
  input  logic [CH_BITS-1:0]    cfg_ch,
  input  logic [DELAY_BITS-1:0] cfg_delay,
  output logic [OUT_BITS-1:0]   out_sample,
  output logic                  out_valid
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_BITS   = $clog2(FRAME_BITS);
  localparam int FILL_BITS  = DELAY_BITS + 1;

  typedef enum logic [1:0] {IDLE, WRITE, ACCUM, OUT} state_t;

  state_t                        state;
  logic [CNT_BITS-1:0]           bit_cnt, bit_cnt_nxt, slot_pos;
  logic                          in_right, capture, frame_end;
  logic [SAMPLE_BITS-1:0]        sh_l [NUM_LINES];
  logic [SAMPLE_BITS-1:0]        sh_r [NUM_LINES];
  logic [SAMPLE_BITS-1:0]        hist [MAX_DELAY][CH];
  logic [DELAY_BITS-1:0]         pend [CH];
  logic [DELAY_BITS-1:0]         act  [CH];
  logic [DELAY_BITS-1:0]         wr_ptr, rd_ptr;
  logic [FILL_BITS-1:0]          fill;
  logic [CH_BITS-1:0]            ch_idx;
  logic [SAMPLE_BITS-1:0]        sample;
  logic signed [OUT_BITS-1:0]    acc, term, sum;
  logic                          cfg_ch_ok;

  if (CH == (1 << CH_BITS)) begin : g_ch_full
    assign cfg_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign cfg_ch_ok = (cfg_ch < CH_BITS'(CH));
  end

  always_comb begin
    frame_end   = (bit_cnt == CNT_BITS'(FRAME_BITS - 1));
    bit_cnt_nxt = frame_end ? '0 : bit_cnt + CNT_BITS'(1);
    in_right    = (bit_cnt >= CNT_BITS'(SLOT_BITS));
    slot_pos    = in_right ? bit_cnt - CNT_BITS'(SLOT_BITS) : bit_cnt;
    capture     = (slot_pos >= CNT_BITS'(1)) && (slot_pos <= CNT_BITS'(SAMPLE_BITS));
    // wr_ptr has already advanced past the slot written this frame
    rd_ptr      = wr_ptr - DELAY_BITS'(1) - act[ch_idx];
    sample      = hist[rd_ptr][ch_idx];
    term        = ({1'b0, act[ch_idx]} < fill)
                  ? {{(OUT_BITS - SAMPLE_BITS){sample[SAMPLE_BITS-1]}}, sample}
                  : '0;
    sum         = ((ch_idx == '0) ? '0 : acc) + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      i2s_ws     <= 1'b0;
      state      <= IDLE;
      wr_ptr     <= '0;
      fill       <= '0;
      ch_idx     <= '0;
      acc        <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
      end
      for (int unsigned k = 0; k < NUM_LINES; k++) begin
        sh_l[k] <= '0;
        sh_r[k] <= '0;
      end
    end else begin
      bit_cnt   <= bit_cnt_nxt;
      i2s_ws    <= (bit_cnt_nxt >= CNT_BITS'(SLOT_BITS));
      out_valid <= 1'b0;
      if (capture) begin
        for (int unsigned k = 0; k < NUM_LINES; k++) begin
          if (in_right) sh_r[k] <= {sh_r[k][SAMPLE_BITS-2:0], i2s_sd[k]};
          else          sh_l[k] <= {sh_l[k][SAMPLE_BITS-2:0], i2s_sd[k]};
        end
      end
      if (cfg_we && cfg_ch_ok) pend[cfg_ch] <= cfg_delay;
      case (state)
        IDLE: if (frame_end) state <= WRITE;
        WRITE: begin
          for (int unsigned i = 0; i < CH; i++) act[i] <= pend[i];
          if (fill != FILL_BITS'(MAX_DELAY)) fill <= fill + FILL_BITS'(1);
          wr_ptr <= wr_ptr + DELAY_BITS'(1);
          ch_idx <= '0;
          state  <= ACCUM;
        end
        ACCUM: begin
          acc    <= sum;
          ch_idx <= ch_idx + CH_BITS'(1);
          // the final sum goes straight to the output so out_valid lands in OUT
          if (ch_idx == CH_BITS'(CH - 1)) begin
            out_sample <= sum;
            out_valid  <= 1'b1;
            state      <= OUT;
          end
        end
        OUT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == WRITE) begin
      for (int unsigned k = 0; k < NUM_LINES; k++) begin
        hist[wr_ptr][2*k]   <= sh_l[k];
        hist[wr_ptr][2*k+1] <= sh_r[k];
      end
    end
  end

endmodule
